demux_1to8_scanner: RTL and testbench
=====================================

# demux_1to8_scanner

Sequential 1-to-8 scanning demultiplexer. It is the receiving end of an 8:1 mux selection path: the block drives the 3-bit select bus of an external 8-to-1 mux and steps it through inputs 0..7. After a programmable settle time at each position, it samples the mux's single-bit output and routes that bit into the matching position of a shadow register. When all eight bits are captured, it presents the reconstructed 8-bit word in parallel with a one-cycle valid strobe.

## Interface
- SETTLE_CYC, default 2: cycles between a select change and the sample of the mux output; legal range 1..15.
- clk  in  1  rising-edge clock; only clock in the block.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin one scan; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at scan completion.
- din  in  1  mux output bit for the current sel.
- sel  out  3  select bus to the external 8:1 mux.
- busy  out  1  high while a scan is in progress.
- dout  out  8  last complete word; bit k = din captured while sel == k.
- valid  out  1  one-cycle pulse: dout was updated.

## Operation
- Reset values (rst_n low at an edge): sel = 0, busy = 0, valid = 0, dout = 8'h00, shadow = 8'h00, settle counter = 0, state = IDLE.
- States:
  - IDLE: start = 1 at an edge → SCAN, sel = 0, busy = 1, counter = SETTLE_CYC-1.
  - SCAN: counter decrements each cycle. At the edge where the counter is 0:
    - shadow[sel] <= din.
    - If sel < 7: sel increments and the counter reloads SETTLE_CYC-1.
    - If sel == 7: go to COMPLETE handling at that same edge (below).
  - COMPLETE handling, at the bit-7 sample edge:
    - dout <= {din, shadow[6:0]}; valid = 1 for the following cycle only.
    - cont = 1: sel <= 0, counter reloads, stay in SCAN, busy stays 1.
    - cont = 0: state <= IDLE, sel <= 0, busy <= 0.
- dout holds the previous word for the whole of a scan. Only the shadow register changes mid-scan.
- start while busy = 1 is ignored; it is not queued.
- start and cont both high at the completion edge: cont governs and start is ignored.
- cont deasserted mid-scan: the current scan finishes normally, then the block goes to IDLE.
- Reset mid-scan: partial word is discarded, no valid, and all outputs return to reset values on that edge.
- din is never sampled in IDLE.

## Timing
- Start accepted at edge S. sel = k during cycles S+k·SETTLE_CYC .. S+(k+1)·SETTLE_CYC-1.
- Bit k sampled at edge S+(k+1)·SETTLE_CYC.
- Scan length is 8·SETTLE_CYC cycles. dout is updated and valid rises at edge S+8·SETTLE_CYC; valid falls one edge later.
- Continuous mode: valid every 8·SETTLE_CYC cycles, with no gap cycles between scans.
- din must be stable from SETTLE_CYC-1 cycles after a sel change through the sample edge. The mux path is combinational; SETTLE_CYC absorbs its settling.
- Earliest new start after a non-continuous completion: the edge after busy falls. busy is 0 for at least one cycle before the next scan.

## Test plan
- **Single scan.** Setup: bench mux model din = pat[sel], pat = 8'b00001001, SETTLE_CYC = 2, start pulsed 1 cycle.
  - sel steps 0,0,1,1,…,7,7.
  - valid is high for exactly 1 cycle, 16 cycles after start is accepted.
  - dout = 8'h09; busy returns to 0.
- **Continuous mode.** Setup: cont = 1, pat = 8'hA5 for the first scan, pat changed to 8'h3C during sel == 0 of the second scan.
  - Two valid pulses, 16 cycles apart.
  - dout = 8'hA5, then 8'h3C.
  - busy stays continuously high.
- **Reset mid-scan.** Stimulus: rst_n low for 1 cycle while sel == 4.
  - All outputs at reset values the next cycle; no valid.
  - A following start with pat = 8'hFF yields dout = 8'hFF only.
- **Start while busy.** Stimulus: extra start pulses at sel == 2 and at the completion edge (cont = 0).
  - Exactly one valid; block returns to IDLE.
  - A start applied at the first cycle busy is 0 is accepted.
- **dout stability.** Setup: prior word 8'h5A, then pat = 8'hC3.
  - dout stays 8'h5A through the whole second scan.
  - dout switches to 8'hC3 only with valid.
- **SETTLE_CYC = 1.** Stimulus: cont = 1, pat = 8'h81.
  - sel increments every cycle.
  - valid every 8 cycles; dout = 8'h81.

Source files
------------

// File: rtl/demux_1to8_scanner.sv
// Scanning 1-to-8 demultiplexer: steps an external 8:1 mux select through 0..7,
// samples its output after a settle time and presents the rebuilt byte with a valid strobe.
module demux_1to8_scanner #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       din,
  output logic [2:0] sel,
  output logic       busy,
  output logic [7:0] dout,
  output logic       valid
);

  localparam logic [3:0] Reload = 4'(SETTLE_CYC - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] shadow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      shadow_q <= 8'h00;
      sel      <= 3'd0;
      busy     <= 1'b0;
      dout     <= 8'h00;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StScan;
            sel     <= 3'd0;
            busy    <= 1'b1;
            cnt_q   <= Reload;
          end
        end
        StScan: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            shadow_q[sel] <= din;
            cnt_q         <= Reload;
            if (sel != 3'd7) begin
              sel <= sel + 3'd1;
            end else begin
              // Bit 7 goes straight into dout; the shadow copy is not yet visible here.
              dout  <= {din, shadow_q[6:0]};
              valid <= 1'b1;
              sel   <= 3'd0;
              if (!cont) begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1to8_scanner.sv
// Self-checking bench for demux_1to8_scanner: two instances (settle 2 and settle 1) compared
// every cycle against a phase-arithmetic model, plus directed literal checks.
module tb_demux_1to8_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: SETTLE_CYC = 2
  logic       rst_n_a = 1'b0, start_a = 1'b0, cont_a = 1'b0;
  logic [7:0] pat_a = 8'h00;
  logic       din_a;
  logic [2:0] sel_a;
  logic       busy_a, valid_a;
  logic [7:0] dout_a;
  assign din_a = pat_a[sel_a];

  // Instance B: SETTLE_CYC = 1
  logic       rst_n_b = 1'b0, start_b = 1'b0, cont_b = 1'b0;
  logic [7:0] pat_b = 8'h00;
  logic       din_b;
  logic [2:0] sel_b;
  logic       busy_b, valid_b;
  logic [7:0] dout_b;
  assign din_b = pat_b[sel_b];

  demux_1to8_scanner #(.SETTLE_CYC(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .cont(cont_a), .din(din_a),
    .sel(sel_a), .busy(busy_a), .dout(dout_a), .valid(valid_a)
  );

  demux_1to8_scanner #(.SETTLE_CYC(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .cont(cont_b), .din(din_b),
    .sel(sel_b), .busy(busy_b), .dout(dout_b), .valid(valid_b)
  );

  // Model: phase = cycles since the scan began; bit k is taken at phase (k+1)*n.
  typedef struct packed {
    bit       active;
    bit [7:0] phase;
    bit [7:0] word;
    bit [7:0] dout;
    bit       valid;
  } mdl_t;

  function automatic mdl_t step(mdl_t m, int n, bit rn, bit st, bit ct, bit [7:0] pat);
    mdl_t r = m;
    int p;
    int k;
    r.valid = 1'b0;
    if (!rn) begin
      r = '0;
    end else if (!m.active) begin
      if (st) begin
        r.active = 1'b1;
        r.phase  = 8'd0;
      end
    end else begin
      p = int'(m.phase) + 1;
      r.phase = 8'(p);
      if (p % n == 0) begin
        k = p / n - 1;
        r.word[k] = pat[k];
        if (k == 7) begin
          r.dout  = r.word;
          r.valid = 1'b1;
          r.phase = 8'd0;
          if (!ct) r.active = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [12:0] expect_of(mdl_t m, int n);
    logic [2:0] s;
    s = m.active ? 3'(int'(m.phase) / n) : 3'd0;
    return {s, m.active, m.dout, m.valid};
  endfunction

  mdl_t ma = '0, mb = '0;
  always @(posedge clk) begin
    ma <= step(ma, 2, rst_n_a, start_a, cont_a, pat_a);
    mb <= step(mb, 1, rst_n_b, start_b, cont_b, pat_b);
  end

  bit chk_en = 1'b0;
  int nvalid_a = 0, nvalid_b = 0, nbusy_lo_a = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests += 2;
      if ({sel_a, busy_a, dout_a, valid_a} !== expect_of(ma, 2)) begin
        n_fail++;
        $display("FAIL cmp_a cyc=%0d got sel/busy/dout/valid=%0d/%0b/%h/%0b expected %0d/%0b/%h/%0b",
                 cyc, sel_a, busy_a, dout_a, valid_a, expect_of(ma, 2) >> 10,
                 expect_of(ma, 2) >> 9 & 1, expect_of(ma, 2) >> 1 & 8'hff, expect_of(ma, 2) & 1);
      end
      if ({sel_b, busy_b, dout_b, valid_b} !== expect_of(mb, 1)) begin
        n_fail++;
        $display("FAIL cmp_b cyc=%0d got sel/busy/dout/valid=%0d/%0b/%h/%0b expected %0d/%0b/%h/%0b",
                 cyc, sel_b, busy_b, dout_b, valid_b, expect_of(mb, 1) >> 10,
                 expect_of(mb, 1) >> 9 & 1, expect_of(mb, 1) >> 1 & 8'hff, expect_of(mb, 1) & 1);
      end
      if (valid_a === 1'b1) nvalid_a++;
      if (valid_b === 1'b1) nvalid_b++;
      if (busy_a !== 1'b1) nbusy_lo_a++;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  int sc;
  task automatic pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    sc = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_valid_a(output int vc);
    vc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_a === 1'b1) begin
        vc = cyc;
        break;
      end
    end
    if (vc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_valid_a timeout got none expected valid pulse");
    end
  endtask

  task automatic wait_valid_b(output int vc);
    vc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_b === 1'b1) begin
        vc = cyc;
        break;
      end
    end
    if (vc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_valid_b timeout got none expected valid pulse");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v1, v2, n0, b0, found;
    bit bad;
    repeat (2) @(negedge clk);
    check("reset_a", {sel_a, busy_a, dout_a, valid_a}, 13'h0);
    check("reset_b", {sel_b, busy_b, dout_b, valid_b}, 13'h0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    chk_en  = 1'b1;
    repeat (3) @(negedge clk);

    // Single scan
    pat_a = 8'b0000_1001;
    pulse_a();
    repeat (4) @(negedge clk);
    check("single_sel_at_s4", sel_a, 3'd2);
    wait_valid_a(v1);
    check("single_latency", v1 - sc, 16);
    check("single_dout", dout_a, 8'h09);
    @(negedge clk);
    check("single_valid_fall", valid_a, 1'b0);
    check("single_busy_fall", busy_a, 1'b0);

    // Continuous mode
    cont_a = 1'b1;
    pat_a  = 8'hA5;
    pulse_a();
    #1 b0 = nbusy_lo_a;
    wait_valid_a(v1);
    check("cont_dout1", dout_a, 8'hA5);
    pat_a = 8'h3C;
    wait_valid_a(v2);
    check("cont_dout2", dout_a, 8'h3C);
    check("cont_period", v2 - v1, 16);
    #1 check("cont_busy_held", nbusy_lo_a - b0, 0);
    cont_a = 1'b0;
    wait_valid_a(v1);
    @(negedge clk);
    check("cont_stop_idle", busy_a, 1'b0);

    // Reset mid-scan
    pat_a = 8'h0F;
    pulse_a();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (sel_a == 3'd4) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reach_sel4", found, 1);
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    check("rst_outputs", {sel_a, busy_a, dout_a, valid_a}, 13'h0);
    #1 n0 = nvalid_a;
    repeat (20) @(negedge clk);
    #1 check("rst_no_valid", nvalid_a - n0, 0);
    pat_a = 8'hFF;
    pulse_a();
    wait_valid_a(v1);
    check("rst_after_dout", dout_a, 8'hFF);
    #1 check("rst_after_one_valid", nvalid_a - n0, 1);

    // Start while busy
    repeat (2) @(negedge clk);
    pat_a = 8'h66;
    pulse_a();
    #1 n0 = nvalid_a;
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    check("busy_start_valid", valid_a, 1'b1);
    check("busy_start_idle", busy_a, 1'b0);
    check("busy_start_dout", dout_a, 8'h66);
    pat_a = 8'h99;
    v2 = sc + 17;
    @(negedge clk);
    start_a = 1'b0;
    check("restart_busy", busy_a, 1'b1);
    wait_valid_a(v1);
    check("restart_latency", v1, v2 + 16);
    check("restart_dout", dout_a, 8'h99);
    #1 check("busy_start_valids", nvalid_a - n0, 2);

    // dout stability
    repeat (2) @(negedge clk);
    pat_a = 8'h5A;
    pulse_a();
    wait_valid_a(v1);
    @(negedge clk);
    pat_a = 8'hC3;
    pulse_a();
    bad = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_a === 1'b1) begin
        found = 1;
        break;
      end
      if (dout_a !== 8'h5A) bad = 1'b1;
      @(negedge clk);
    end
    check("stable_hold", bad, 1'b0);
    check("stable_valid_seen", found, 1);
    check("stable_new_dout", dout_a, 8'hC3);

    // SETTLE_CYC = 1, continuous
    cont_b = 1'b1;
    pat_b  = 8'h81;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_valid_b(v1);
    check("s1_sel_at_valid", sel_b, 3'd0);
    @(negedge clk);
    check("s1_sel_next", sel_b, 3'd1);
    wait_valid_b(v2);
    check("s1_period", v2 - v1, 8);
    check("s1_dout", dout_b, 8'h81);
    cont_b = 1'b0;
    wait_valid_b(v1);
    @(negedge clk);
    check("s1_idle", busy_b, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
